// File: rtl/dot_pkg.sv
// Shared constants and state encoding for the dot convolution feeder.
// Frame geometry: 12 positions x 32 channels of 3x3 windows.
package dot_pkg;

  localparam int DATA_LEN_DEF = 8;

  localparam int FRAME_WORDS = 384;
  localparam int N_POS = 12;
  localparam int N_CH = 32;
  localparam int N_TAPS = 9;
  localparam int CNT_W = 9;

  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/dot_result_serializer.sv
// Captures a wide result vector in one cycle and streams it out
// one DATA_LEN value per valid/ready beat, lowest index first.
module dot_result_serializer
  import dot_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int N_WORDS = FRAME_WORDS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [N_WORDS*DATA_LEN-1:0] load_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_LEN-1:0]         out_data,
  output logic                        out_last,
  output logic                        done
);

  localparam int RW = $clog2(N_WORDS);
  localparam logic [RW-1:0] RD_LAST = RW'(N_WORDS - 1);

  logic [N_WORDS*DATA_LEN-1:0] result;
  logic                        active;
  logic [RW-1:0]               rd_cnt;
  logic                        fire;
  logic                        rd_last;
  logic                        take;

  assign take = load && !active;
  assign fire = active && out_ready;
  assign rd_last = (rd_cnt == RD_LAST);

  assign out_valid = active;
  assign out_last = active && rd_last;
  assign out_data =
    result[int'(rd_cnt)*DATA_LEN +: DATA_LEN];
  assign done = fire && rd_last;

  // Data register is never reset; only the control state is.
  always_ff @(posedge clk) begin
    if (take) begin
      result <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      rd_cnt <= '0;
    end else if (take) begin
      active <= 1'b1;
      rd_cnt <= '0;
    end else if (fire) begin
      if (rd_last) begin
        active <= 1'b0;
        rd_cnt <= '0;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dot_feeder.sv
// Frame buffer and load/capture sequencer in front of the dot engine.
// Fills 384 windows, holds load until valid, then drains results.
module dot_feeder
  import dot_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_TAPS*DATA_LEN-1:0]       in_data,
  output logic                             dot_load,
  output logic [N_POS*288*DATA_LEN-1:0]    dot_d,
  input  logic                             dot_valid,
  input  logic [N_CH*N_POS*DATA_LEN-1:0]   dot_q,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_LEN-1:0]              out_data,
  output logic                             out_last,
  output logic                             busy
);

  localparam int WW = N_TAPS * DATA_LEN;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wr_cnt;
  logic [WW-1:0]    fbuf [FRAME_WORDS];
  logic             in_fire;
  logic             wr_last;
  logic             capture;
  logic             ser_done;

  assign in_ready = (state_q == ST_FILL);
  assign dot_load = (state_q == ST_RUN);
  assign in_fire = in_valid && in_ready;
  assign wr_last = (wr_cnt == LAST_IDX);
  assign capture = dot_load && dot_valid;
  assign busy = !((state_q == ST_FILL) && (wr_cnt == '0));

  always_ff @(posedge clk) begin
    if (in_fire) begin
      fbuf[wr_cnt] <= in_data;
    end
  end

  for (genvar k = 0; k < FRAME_WORDS; k++) begin : g_slot
    assign dot_d[k*WW +: WW] = fbuf[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      wr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_FILL): begin
        if (in_fire && wr_last) state_d = ST_RUN;
      end
      (state_q == ST_RUN): begin
        if (dot_valid) state_d = ST_DRAIN;
      end
      (state_q == ST_DRAIN): begin
        if (ser_done) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  dot_result_serializer #(
    .DATA_LEN (DATA_LEN),
    .N_WORDS  (FRAME_WORDS)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (capture),
    .load_data (dot_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (ser_done)
  );

endmodule
